// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - shared register-bus arbiter and transaction engine.
// Optional: define ARB_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
package led_driver_pkg;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;
endpackage

module reg_bus_arbiter
  import led_driver_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int AW      = ADDR_BITS,
  parameter int DW      = DATA_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_wr,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic [AW-1:0]         bus_addr,
  output logic                  bus_w_en,
  output logic                  bus_r_en,
  output logic [DW-1:0]         bus_wdata,
  input  logic [DW-1:0]         bus_rdata
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_WR,
    ARB_RD1,
    ARB_RD2,
    ARB_ACK
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               found;
  logic [IW-1:0]      pick;
  logic [IW-1:0]      cand;
`ifndef ARB_FIXED_PRIO_EN
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
`endif

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`else
    // Search rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ; first hit wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d = rr_ptr_q;
`endif
    bus_w_en = 1'b0;
    bus_r_en = 1'b0;
    ack      = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          grant_d  = NUM_REQ'(1) << pick;
          addr_d   = req_addr[pick*AW +: AW];
          wdata_d  = req_wdata[pick*DW +: DW];
          state_d  = req_wr[pick] ? ARB_WR : ARB_RD1;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
`endif
        end
      end
      ARB_WR: begin
        bus_w_en = 1'b1;
        ack      = grant_q;
        grant_d  = '0;
        state_d  = ARB_IDLE;
      end
      ARB_RD1: begin
        bus_r_en = 1'b1;
        state_d  = ARB_RD2;
      end
      ARB_RD2: begin
        bus_r_en = 1'b1;
        rdata_d  = bus_rdata;
        state_d  = ARB_ACK;
      end
      ARB_ACK: begin
        ack     = grant_q;
        grant_d = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != ARB_IDLE);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - randomized bench with transaction-level reference model.
module tb_reg_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] bus_rdata = '0;
  logic [N-1:0]  grant, ack;
  logic [DW-1:0] rdata, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic          busy, bus_w_en, bus_r_en;

  int vectors = 0;
  int miscompares = 0;

  // Reference: one in-flight transaction, tracked by cycles elapsed since its grant.
  bit            m_active, m_wr;
  int            m_win, m_phase, m_rr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [N-1:0]  e_ack;

  reg_bus_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .ack(ack),
    .rdata(rdata), .busy(busy), .bus_addr(bus_addr), .bus_w_en(bus_w_en),
    .bus_r_en(bus_r_en), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_wr = 0; m_win = 0; m_phase = 0; m_rr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; e_ack = '0;
  endtask

  task automatic model_step();
    int w;
    w = -1;
    if (!reset_n) return;
    if (!m_active) begin
      if (req != '0) begin
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (w < 0 && req[k]) w = k;
`else
        for (int k = 0; k < N; k++) if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
        m_rr = (w + 1) % N;
`endif
        m_active = 1;
        m_win    = w;
        m_wr     = req_wr[w];
        m_addr   = req_addr[w*AW +: AW];
        m_wdata  = req_wdata[w*DW +: DW];
        m_phase  = 1;
      end
    end else if (m_wr || m_phase == 3) begin
      m_active = 0;
    end else begin
      if (m_phase == 2) m_rdata = bus_rdata;
      m_phase++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = m_active ? (N'(1) << m_win) : '0;
    e_ack = (m_active && ((m_wr && m_phase == 1) || (!m_wr && m_phase == 3))) ? eg : '0;
    chk("grant", grant, eg);
    chk("ack", ack, e_ack);
    chk("bus_w_en", bus_w_en, m_active && m_wr);
    chk("bus_r_en", bus_r_en, m_active && !m_wr && m_phase <= 2);
    chk("busy", busy, m_active);
    chk("rdata", rdata, m_rdata);
    chk("bus_addr", bus_addr, m_addr);
    chk("bus_wdata", bus_wdata, m_wdata);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Called just after a negedge; returns at a later negedge with reset released.
  task automatic apply_reset();
    req = '0;
    #1;
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  initial begin
    logic [N-1:0] order[$];
    logic [N-1:0] prev_g;
    int wcount, rcount;

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_w_en", bus_w_en, 0);
    chk("reset_rdata", rdata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single write
    set_req(0, 1'b1, 8'h03, 8'hA5);
    cycle();
    chk("wr_w_en", bus_w_en, 1);
    chk("wr_addr", bus_addr, 8'h03);
    chk("wr_wdata", bus_wdata, 8'hA5);
    chk("wr_ack", ack, 3'b001);
    req = '0;
    cycle();
    chk("wr_bubble_busy", busy, 0);

    // Single read
    set_req(0, 1'b0, 8'h07, 8'h00);
    bus_rdata = 8'h5C;
    cycle();
    chk("rd_r_en1", bus_r_en, 1);
    cycle();
    chk("rd_r_en2", bus_r_en, 1);
    cycle();
    chk("rd_ack", ack, 3'b001);
    chk("rd_rdata", rdata, 8'h5C);
    req = '0;
    bus_rdata = 8'h00;
    cycle();
    chk("rd_rdata_hold", rdata, 8'h5C);

    // Two requesters held continuously
    apply_reset();
    set_req(0, 1'b1, 8'h10, 8'h01);
    set_req(1, 1'b1, 8'h20, 8'h02);
    prev_g = '0;
    repeat (8) begin
      cycle();
      if (grant != '0 && prev_g == '0) order.push_back(grant);
      prev_g = grant;
    end
    chk("rr_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++) begin
`ifdef ARB_FIXED_PRIO_EN
      chk("prio_order", order[k], 3'b001);
`else
      chk("rr_order", order[k], (k % 2 == 0) ? 3'b001 : 3'b010);
`endif
    end
    req = '0;
    cycle();

    // Requester 0 abandons its read after the grant
    apply_reset();
    set_req(0, 1'b0, 8'h44, 8'h00);
    set_req(1, 1'b1, 8'h33, 8'h99);
    bus_rdata = 8'h6E;
    cycle();
    chk("drop_grant0", grant, 3'b001);
    req[0] = 1'b0;
    req_addr[0 +: AW] = 8'hEE;
    cycle();
    cycle();
    chk("drop_ack0", ack, 3'b001);
    chk("drop_rdata", rdata, 8'h6E);
    cycle();
    cycle();
    chk("drop_grant1", grant, 3'b010);
    chk("drop_addr1", bus_addr, 8'h33);
    req = '0;
    cycle();

    // Back-to-back writes from requester 1
    apply_reset();
    set_req(1, 1'b1, 8'h55, 8'h66);
    wcount = 0;
    rcount = 0;
    repeat (8) begin
      cycle();
      if (bus_w_en) wcount++;
      if (bus_r_en) rcount++;
    end
    chk("b2b_w_count", wcount, 4);
    chk("b2b_r_count", rcount, 0);
    req = '0;
    cycle();

    // Reset in the middle of a read
    apply_reset();
    set_req(0, 1'b0, 8'h07, 8'h00);
    cycle();
    chk("mid_r_en_pre", bus_r_en, 1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_r_en", bus_r_en, 0);
    chk("mid_grant", grant, 0);
    chk("mid_ack", ack, 0);
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    chk("mid_busy_after", busy, 0);

    // Randomized traffic
    apply_reset();
    repeat (3000) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(3) == 0) set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
        end else if (m_active && m_win == i) begin
          if ($urandom_range(7) == 0) begin
            req_addr[i*AW +: AW] = 8'($urandom);
            req_wdata[i*DW +: DW] = 8'($urandom);
          end else if ($urandom_range(15) == 0) begin
            req[i] = 1'b0;
          end
        end
      end
      bus_rdata = 8'($urandom);
      if ($urandom_range(499) == 0) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
